param_down_counter_uf: RTL and testbench
========================================

Name: param_down_counter_uf

Overview:
- Registered, loadable down-counter with a programmable decrement step and correct underflow (borrow) detection.
- Underflow policy is selectable by parameter: wrap, saturate at zero, or auto-reload.
- Successor to the fixed 4-bit combinational decrementer, whose underflow flag was tied low.
- Used as a timeout, credit or countdown source in the medium-complexity datapath blocks.

Parameters:
- WIDTH, 4, counter, step and reload datapath width in bits (legal range 2..32).
- MODE, 0, underflow policy: 0 = wrap modulo 2^WIDTH; 1 = saturate at 0; 2 = auto-reload from reload_value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load count from load_value this cycle.
- load_value  input  WIDTH  value written on load.
- en  input  1  decrement enable.
- step  input  WIDTH  decrement amount, unsigned; sampled when en=1.
- reload_value  input  WIDTH  value used on underflow when MODE=2; ignored otherwise.
- clr_sticky  input  1  clears underflow_sticky.
- count  output  WIDTH  registered counter value.
- zero  output  1  combinational, count == 0.
- underflow  output  1  registered one-cycle pulse: the last update borrowed.
- underflow_sticky  output  1  registered latch of any underflow since the last clear.

Behaviour:
- All state updates on the rising clk edge.
- Priority: rst > load > en > hold.
- Reset: count=0, underflow=0, underflow_sticky=0, so zero=1 after reset.
- rst asserted mid-operation overrides load, en and clr_sticky in the same cycle.
- load=1: count <= load_value; underflow <= 0. A simultaneous en is ignored and no borrow is evaluated.
- en=1, load=0, step <= count: count <= count - step; underflow <= 0.
- en=1, load=0, step > count (borrow): underflow <= 1; count depends on MODE.
  - MODE 0: count <= (count - step) mod 2^WIDTH.
  - MODE 1: count <= 0.
  - MODE 2: count <= reload_value.
- step = 0 with en=1: count holds; underflow <= 0.
- count == step: count becomes 0. This is not an underflow.
- en=0 and load=0: count holds; underflow <= 0. The pulse never lasts more than one cycle unless borrows occur on consecutive cycles.
- Latency: count and underflow reflect the inputs sampled at edge N from edge N onward. zero follows count combinationally.
- Borrow detection compares full WIDTH-bit unsigned values (equivalently, the carry-out of a WIDTH+1-bit subtraction). No truncation before the compare.
- underflow_sticky:
  - set when underflow is set in the same cycle;
  - otherwise cleared by clr_sticky;
  - a set and a clr_sticky in the same cycle: set wins (sticky=1).
- MODE outside 0..2 is illegal. An elaboration-time check must flag it.
- No X propagation: all outputs are defined every cycle after the first reset.

Test Plan (WIDTH=4):
- rst=1 for 2 cycles -> count=0, zero=1, underflow=0, underflow_sticky=0.
- MODE 0: load 5, then en with step=1 for 6 cycles -> count 4,3,2,1,0,15. underflow pulses only on the 0->15 edge, then sticky=1.
- MODE 1: load 3, en step=5 -> count=0, underflow=1 for one cycle. Next en step=1 -> count=0, underflow=1 again. Then clr_sticky -> sticky=0.
- MODE 2, reload_value=12: load 2, en step=2 -> count=0, no underflow. Next en step=1 -> count=12, underflow=1.
- Corner cases:
  - load=1 with en=1, load_value=8, count=0, step=3 -> count=8, underflow=0.
  - en with step=0 at count=0 -> count=0, underflow=0.
- clr_sticky=1 in the same cycle as a borrow -> underflow_sticky=1.
- rst during active decrement at count=7 -> count=0 next edge.

Source files
------------

// File: rtl/param_down_counter_uf_if.sv
// Control and status bundle for param_down_counter_uf.
// The master drives load/decrement requests; the slave (the counter) returns its state.
interface param_down_counter_uf_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             en;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] reload_value;
  logic             clr_sticky;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             underflow;
  logic             underflow_sticky;

  modport master (
    output load, load_value, en, step, reload_value, clr_sticky,
    input  count, zero, underflow, underflow_sticky
  );

  modport slave (
    input  load, load_value, en, step, reload_value, clr_sticky,
    output count, zero, underflow, underflow_sticky
  );
endinterface

// File: rtl/param_down_counter_uf.sv
// Loadable down-counter with programmable step and borrow detection.
// MODE selects the underflow policy: 0 wrap, 1 saturate at zero, 2 auto-reload.
module param_down_counter_uf #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  param_down_counter_uf_if.slave bus
);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $fatal(1, "param_down_counter_uf: MODE must be 0, 1 or 2");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "param_down_counter_uf: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] count_reg, count_next;
  logic             underflow_reg, underflow_next;
  logic             sticky_reg, sticky_next;
  logic [WIDTH:0]   diff_ext;
  logic             borrow;
  logic [WIDTH-1:0] borrow_value;

  // One extra bit so the borrow is the carry-out of the full-width subtraction.
  assign diff_ext = {1'b0, count_reg} - {1'b0, bus.step};
  assign borrow   = diff_ext[WIDTH];

  if (MODE == 1) begin : g_saturate
    assign borrow_value = '0;
  end else if (MODE == 2) begin : g_reload
    assign borrow_value = bus.reload_value;
  end else begin : g_wrap
    assign borrow_value = diff_ext[WIDTH-1:0];
  end

  always_comb begin
    count_next     = count_reg;
    underflow_next = 1'b0;
    if (bus.load) begin
      count_next = bus.load_value;
    end else if (bus.en) begin
      if (borrow) begin
        count_next     = borrow_value;
        underflow_next = 1'b1;
      end else begin
        count_next = diff_ext[WIDTH-1:0];
      end
    end
  end

  // A new borrow outranks a simultaneous clear so no event is lost.
  always_comb begin
    sticky_next = sticky_reg;
    if (underflow_next) begin
      sticky_next = 1'b1;
    end else if (bus.clr_sticky) begin
      sticky_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      underflow_reg <= 1'b0;
      sticky_reg    <= 1'b0;
    end else begin
      count_reg     <= count_next;
      underflow_reg <= underflow_next;
      sticky_reg    <= sticky_next;
    end
  end

  assign bus.count            = count_reg;
  assign bus.zero             = (count_reg == '0);
  assign bus.underflow        = underflow_reg;
  assign bus.underflow_sticky = sticky_reg;

endmodule

// File: tb/tb_param_down_counter_uf.sv
// Drives identical stimulus into all three MODE variants (WIDTH=4) and compares
// each against an arithmetic reference model, directed plan first, then random.
module tb_param_down_counter_uf;
  localparam int W = 4;
  localparam int M = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_down_counter_uf_if #(.WIDTH(W)) bus0 ();
  param_down_counter_uf_if #(.WIDTH(W)) bus1 ();
  param_down_counter_uf_if #(.WIDTH(W)) bus2 ();

  param_down_counter_uf #(.WIDTH(W), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  param_down_counter_uf #(.WIDTH(W), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  param_down_counter_uf #(.WIDTH(W), .MODE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;
  int mc[3], mu[3], ms[3];

  int s_load, s_lv, s_en, s_step, s_rv, s_clr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int ld, input int lv, input int e, input int st, input int rv, input int clr);
    s_load = ld; s_lv = lv; s_en = e; s_step = st; s_rv = rv; s_clr = clr;
    bus0.load = 1'(ld); bus0.load_value = 4'(lv); bus0.en = 1'(e);
    bus0.step = 4'(st); bus0.reload_value = 4'(rv); bus0.clr_sticky = 1'(clr);
    bus1.load = 1'(ld); bus1.load_value = 4'(lv); bus1.en = 1'(e);
    bus1.step = 4'(st); bus1.reload_value = 4'(rv); bus1.clr_sticky = 1'(clr);
    bus2.load = 1'(ld); bus2.load_value = 4'(lv); bus2.en = 1'(e);
    bus2.step = 4'(st); bus2.reload_value = 4'(rv); bus2.clr_sticky = 1'(clr);
  endtask

  // Reference: integer subtraction, a negative result is a borrow.
  task automatic model_update();
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        mc[m] = 0; mu[m] = 0; ms[m] = 0;
      end else begin
        if (s_load != 0) begin
          mc[m] = s_lv; mu[m] = 0;
        end else if (s_en != 0) begin
          int d;
          d = mc[m] - s_step;
          if (d < 0) begin
            mu[m] = 1;
            case (m)
              0: mc[m] = d + M;
              1: mc[m] = 0;
              default: mc[m] = s_rv;
            endcase
          end else begin
            mc[m] = d; mu[m] = 0;
          end
        end else begin
          mu[m] = 0;
        end
        if (mu[m] == 1) ms[m] = 1;
        else if (s_clr != 0) ms[m] = 0;
      end
    end
  endtask

  task automatic check_mode(input int m, input logic [3:0] c, input logic z, input logic u, input logic s);
    string p;
    p = $sformatf("mode%0d", m);
    check({p, ".count"}, 32'(c), 32'(mc[m]));
    check({p, ".zero"}, 32'(z), (mc[m] == 0) ? 32'd1 : 32'd0);
    check({p, ".underflow"}, 32'(u), 32'(mu[m]));
    check({p, ".sticky"}, 32'(s), 32'(ms[m]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_mode(0, bus0.count, bus0.zero, bus0.underflow, bus0.underflow_sticky);
    check_mode(1, bus1.count, bus1.zero, bus1.underflow, bus1.underflow_sticky);
    check_mode(2, bus2.count, bus2.zero, bus2.underflow, bus2.underflow_sticky);
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      mc[m] = 0; mu[m] = 0; ms[m] = 0;
    end
    drive(0, 0, 0, 0, 12, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    drive(1, 5, 0, 0, 12, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 1, 12, 0); tick();
    end
    drive(1, 3, 0, 0, 12, 0); tick();
    drive(0, 0, 1, 5, 12, 0); tick();
    drive(0, 0, 1, 1, 12, 0); tick();
    drive(0, 0, 0, 0, 12, 1); tick();
    drive(1, 2, 0, 0, 12, 0); tick();
    drive(0, 0, 1, 2, 12, 0); tick();
    drive(0, 0, 1, 1, 12, 0); tick();
    drive(1, 0, 0, 0, 12, 0); tick();
    drive(1, 8, 1, 3, 12, 0); tick();
    drive(1, 0, 0, 0, 12, 0); tick();
    drive(0, 0, 1, 0, 12, 0); tick();
    drive(0, 0, 1, 1, 12, 1); tick();
    drive(0, 0, 0, 0, 12, 0); tick();
    drive(1, 7, 0, 0, 12, 0); tick();
    drive(0, 0, 1, 1, 12, 1);
    rst = 1'b1; tick();
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive(($urandom_range(0, 5) == 0) ? 1 : 0,
            int'($urandom_range(0, M - 1)),
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, M - 1)) : int'($urandom_range(0, 3)),
            int'($urandom_range(0, M - 1)),
            ($urandom_range(0, 7) == 0) ? 1 : 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
